// File: rtl/fdiv.sv
// fdiv: multi-cycle single-precision divider, y = x1 / x2.
// Restoring radix-2 mantissa division, one quotient bit per cycle, behind a
// start/ready/valid handshake. The number format matches the pipelined fmul:
// no NaN/Inf handling, truncation, flush-to-zero on underflow, and saturation
// to an infinity pattern on overflow or division by a zero/denormal divisor.
// Latency is fixed at 26 cycles from the accepting edge to valid, with no
// early exit for special operands.
module fdiv #(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        ready,
  output logic        valid,
  output logic [31:0] y
);

  // Only the 25-bit quotient (1 integer + 24 fraction bits) is supported.
  localparam logic [4:0] CNT_INIT = 5'(QBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t      state_q,        state_d;
  logic        sign_q,         sign_d;
  logic [7:0]  exp1_q,         exp1_d;
  logic [7:0]  exp2_q,         exp2_d;
  logic [23:0] divisor_q,      divisor_d;
  logic [25:0] rem_q,          rem_d;
  logic [24:0] quot_q,         quot_d;
  logic [4:0]  cnt_q,          cnt_d;
  logic        divByZero_q,    divByZero_d;
  logic        dividendZero_q, dividendZero_d;
  logic        valid_q,        valid_d;
  logic [31:0] y_q,            y_d;

  logic [25:0]       divisorWide;
  logic [25:0]       remDiff;
  logic              remGeq;
  logic signed [9:0] expAdj;
  logic [22:0]       mantOut;
  logic [31:0]       result;

  // Trial subtraction for the current restoring-division step.
  always_comb begin
    divisorWide = {2'b00, divisor_q};
    remGeq      = (rem_q >= divisorWide);
    remDiff     = rem_q - divisorWide;
  end

  // Normalise the finished quotient and apply the special-case priority:
  // bad divisor, zero dividend, underflow, overflow, then the normal result.
  always_comb begin
    if (quot_q[24]) begin
      mantOut = quot_q[23:1];
      expAdj  = $signed({2'b00, exp1_q}) - $signed({2'b00, exp2_q}) + 10'sd127;
    end else begin
      mantOut = quot_q[22:0];
      expAdj  = $signed({2'b00, exp1_q}) - $signed({2'b00, exp2_q}) + 10'sd126;
    end

    if (divByZero_q) begin
      result = {sign_q, 8'hFF, 23'h0};
    end else if (dividendZero_q) begin
      result = {sign_q, 31'h0};
    end else if (expAdj <= 10'sd0) begin
      result = {sign_q, 31'h0};
    end else if (expAdj >= 10'sd255) begin
      result = {sign_q, 8'hFF, 23'h0};
    end else begin
      result = {sign_q, expAdj[7:0], mantOut};
    end
  end

  // Next-state logic: latch operands in IDLE, iterate in CALC, publish in NORM.
  always_comb begin
    state_d        = state_q;
    sign_d         = sign_q;
    exp1_d         = exp1_q;
    exp2_d         = exp2_q;
    divisor_d      = divisor_q;
    rem_d          = rem_q;
    quot_d         = quot_q;
    cnt_d          = cnt_q;
    divByZero_d    = divByZero_q;
    dividendZero_d = dividendZero_q;
    valid_d        = 1'b0;
    y_d            = y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d         = x1[31] ^ x2[31];
          exp1_d         = x1[30:23];
          exp2_d         = x2[30:23];
          divisor_d      = {1'b1, x2[22:0]};
          rem_d          = {2'b00, 1'b1, x1[22:0]};
          quot_d         = '0;
          cnt_d          = CNT_INIT;
          divByZero_d    = (x2[30:23] == 8'h00);
          dividendZero_d = (x1[30:23] == 8'h00);
          state_d        = CALC;
        end
      end

      CALC: begin
        if (remGeq) begin
          quot_d = {quot_q[23:0], 1'b1};
          rem_d  = {remDiff[24:0], 1'b0};
        end else begin
          quot_d = {quot_q[23:0], 1'b0};
          rem_d  = {rem_q[24:0], 1'b0};
        end
        if (cnt_q == 5'd0) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      NORM: begin
        y_d     = result;
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight division.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      sign_q         <= 1'b0;
      exp1_q         <= 8'h00;
      exp2_q         <= 8'h00;
      divisor_q      <= 24'h0;
      rem_q          <= 26'h0;
      quot_q         <= 25'h0;
      cnt_q          <= 5'd0;
      divByZero_q    <= 1'b0;
      dividendZero_q <= 1'b0;
      valid_q        <= 1'b0;
      y_q            <= 32'h0;
    end else begin
      state_q        <= state_d;
      sign_q         <= sign_d;
      exp1_q         <= exp1_d;
      exp2_q         <= exp2_d;
      divisor_q      <= divisor_d;
      rem_q          <= rem_d;
      quot_q         <= quot_d;
      cnt_q          <= cnt_d;
      divByZero_q    <= divByZero_d;
      dividendZero_q <= dividendZero_d;
      valid_q        <= valid_d;
      y_q            <= y_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign valid = valid_q;
  assign y     = y_q;

endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: scoreboard bench for fdiv. Stimulus pushes hand-computed results
// into queues; an independent monitor pops and compares on every valid.
module tb_fdiv;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        ready;
  logic        valid;
  logic [31:0] y;

  int errors     = 0;
  int checks     = 0;
  int edgeCount  = 0;
  int issueCount = 0;
  int validCount = 0;

  logic [31:0] expY[$];
  int          expEdge[$];
  string       expName[$];

  fdiv #(.QBITS(25)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .x1    (x1),
    .x2    (x2),
    .ready (ready),
    .valid (valid),
    .y     (y)
  );

  always #5 clk = ~clk;

  // Count rising edges so latency can be measured in cycles.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      validCount++;
      if (expY.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected valid: got y=%h, expected no result", y);
      end else begin
        logic [31:0] ey;
        int          ee;
        string       en;
        ey = expY.pop_front();
        ee = expEdge.pop_front();
        en = expName.pop_front();
        checkOutput({en, " y"}, y, ey);
        checkOutput({en, " latency"}, 32'(edgeCount - ee), 32'd26);
      end
    end
  end

  // Wait for ready, present one request and record the accepting edge.
  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expected, output int startEdge);
    int waited = 0;
    @(negedge clk);
    while (ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s ready timeout: got ready=%b, expected 1", name, ready);
      startEdge = -1;
      return;
    end
    x1    = a;
    x2    = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    startEdge = edgeCount;
    expY.push_back(expected);
    expEdge.push_back(startEdge);
    expName.push_back(name);
    issueCount++;
    start = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (expY.size() > 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    if (expY.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: got %0d outstanding, expected 0", expY.size());
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  initial begin
    int s1;
    int s2;
    int lowCount;
    int w;

    vecs[0]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA};
    vecs[1]  = '{32'hBF800000, 32'h3F000000, 32'hC0000000};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000};
    vecs[3]  = '{32'h80000000, 32'h3F800000, 32'h80000000};
    vecs[4]  = '{32'h00800000, 32'h7F000000, 32'h00000000};
    vecs[5]  = '{32'h7F000000, 32'h3F000000, 32'h7F800000};
    vecs[6]  = '{32'h40000000, 32'hC0800000, 32'hBF000000};
    vecs[7]  = '{32'h3FC00000, 32'h3FA00000, 32'h3F999999};
    vecs[8]  = '{32'hBF800000, 32'h00400000, 32'hFF800000};
    vecs[9]  = '{32'h00000000, 32'h00000000, 32'h7F800000};
    vecs[10] = '{32'h7F800000, 32'h7F800000, 32'h3F800000};

    rstn  = 1'b0;
    start = 1'b0;
    x1    = 32'h0;
    x2    = 32'h0;
    #1;
    checkOutput("reset ready", {31'h0, ready}, 32'h1);
    checkOutput("reset valid", {31'h0, valid}, 32'h0);
    checkOutput("reset y", y, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    $display("[TB] basic 6/2 with ready-low window");
    applyStimulus("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, s1);
    lowCount = 0;
    w = 0;
    do begin
      @(negedge clk);
      if (ready === 1'b0) lowCount++;
      w++;
    end while (ready !== 1'b1 && w < 40);
    checkOutput("ready low cycles", 32'(lowCount), 32'd26);
    drain();

    $display("[TB] directed vectors, issued back to back");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, s1);
    end
    drain();

    $display("[TB] back-to-back spacing");
    applyStimulus("b2b first", 32'h40C00000, 32'h40000000, 32'h40400000, s1);
    applyStimulus("b2b second", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, s2);
    checkOutput("b2b spacing", 32'(s2 - s1), 32'd27);
    drain();

    $display("[TB] start while busy is ignored");
    applyStimulus("busy op", 32'h40C00000, 32'h40000000, 32'h40400000, s1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    x1    = 32'h3F800000;
    x2    = 32'h40400000;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1;
    x1    = 32'h7F000000;
    x2    = 32'h3F000000;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (30) @(negedge clk);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus("aborted", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, s1);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("mid reset ready", {31'h0, ready}, 32'h1);
    checkOutput("mid reset valid", {31'h0, valid}, 32'h0);
    checkOutput("mid reset y", y, 32'h0);
    expY.delete();
    expEdge.delete();
    expName.delete();
    issueCount--;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus("after reset", 32'hBF800000, 32'h3F000000, 32'hC0000000, s1);
    drain();

    checkOutput("valid count", 32'(validCount), 32'(issueCount));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
